// File: rtl/lc3_pkg.sv
// lc3_pkg: shared word/byte widths and the program-loader state encoding
package lc3_pkg;
  localparam int LC3_WORD_W = 16;
  localparam int LC3_BYTE_W = 8;
  typedef logic [LC3_WORD_W-1:0] word_t;
  typedef logic [LC3_BYTE_W-1:0] byte_t;
  typedef enum logic [3:0] {
    IDLE, ORIG_H, ORIG_L, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, CSUM_H, CSUM_L, DONE, ERR
  } ld_state_t;
endpackage

// File: rtl/lc3_word_assembler.sv
// lc3_word_assembler: pairs stream bytes into big-endian words and keeps the running XOR checksum
//   start     first byte of a frame: latch high byte, clear checksum
//   accept    byte handshake this cycle
//   xor_en    fold the completed word into the checksum
//   byte_data stream byte
//   phase     1 when the next accepted byte is a low byte
//   word      {latched high byte, byte_data}; valid on a low-byte accept
//   csum      XOR of all folded words of the current frame
module lc3_word_assembler
  import lc3_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  input  logic  accept,
  input  logic  xor_en,
  input  byte_t byte_data,
  output logic  phase,
  output word_t word,
  output word_t csum
);
  byte_t hi;
  assign word = {hi, byte_data};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hi    <= '0;
      phase <= 1'b0;
      csum  <= '0;
    end else if (start) begin
      hi    <= byte_data;
      phase <= 1'b1;
      csum  <= '0;
    end else if (accept) begin
      hi    <= phase ? hi : byte_data;
      phase <= ~phase;
      csum  <= (phase && xor_en) ? csum ^ word : csum;
    end
endmodule

// File: rtl/lc3_program_loader.sv
// lc3_program_loader: byte-stream object loader writing LC-3 memory through the direct-load port
//   clk, reset (async, active-low)
//   byte_valid/byte_data/byte_ready  valid/ready byte stream in
//   mem_addr/mem_data/mem_we         direct-port write, one-cycle strobe
//   cpu_hold                         CPU reset request while a frame is in progress
//   start_pc                         origin of the last good frame
//   load_done                        one-cycle pulse on a good frame
//   load_error                       sticky until the next frame starts
module lc3_program_loader
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit CHECKSUM_EN    = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  byte_valid,
  input  byte_t byte_data,
  output logic  byte_ready,
  output word_t mem_addr,
  output word_t mem_data,
  output logic  mem_we,
  output logic  cpu_hold,
  output word_t start_pc,
  output logic  load_done,
  output logic  load_error
);
  localparam ld_state_t TAIL = CHECKSUM_EN ? CSUM_H : DONE;
  ld_state_t state, state_nx;
  word_t orig, addr, rem, word, csum;
  logic [15:0] tmo;
  logic phase, accept, running, timeout, wdone;
  assign accept  = byte_valid && byte_ready;
  assign wdone   = accept && phase;
  assign running = byte_ready && state != IDLE;
  assign timeout = TIMEOUT_CYCLES != 0 && running && !accept && tmo == 16'(TIMEOUT_CYCLES - 1);
  lc3_word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .start    (accept && state == IDLE),
    .accept   (accept),
    .xor_en   (state != CSUM_L),
    .byte_data(byte_data),
    .phase    (phase),
    .word     (word),
    .csum     (csum)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  // IDLE doubles as ORIG_H: the first byte of a frame is the origin high byte.
  always_comb begin
    state_nx = state;
    if (timeout) state_nx = ERR;
    else
      case (state)
        IDLE, ORIG_H: if (accept) state_nx = ORIG_L;
        ORIG_L:       if (accept) state_nx = LEN_H;
        LEN_H:        if (accept) state_nx = LEN_L;
        LEN_L:        if (accept) state_nx = word == '0 ? TAIL : DATA_H;
        DATA_H:       if (accept) state_nx = DATA_L;
        DATA_L:       if (accept) state_nx = WRITE;
        WRITE:        state_nx = rem == 16'd1 ? TAIL : DATA_H;
        CSUM_H:       if (accept) state_nx = CSUM_L;
        CSUM_L:       if (accept) state_nx = csum == word ? DONE : ERR;
        default:      state_nx = IDLE;
      endcase
  end
  // byte_ready is gated by reset so the source sees it low for the whole reset pulse.
  always_comb begin
    byte_ready = reset && !(state inside {WRITE, DONE, ERR});
    mem_we     = state == WRITE;
    load_done  = state == DONE;
    cpu_hold   = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      orig       <= '0;
      addr       <= '0;
      rem        <= '0;
      tmo        <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      start_pc   <= '0;
      load_error <= 1'b0;
    end else begin
      tmo <= (accept || !running) ? '0 : tmo + 16'd1;
      if (state == ORIG_L && wdone) orig <= word;
      if (state == LEN_L && wdone) begin
        rem  <= word;
        addr <= orig;
      end
      if (state == DATA_L && wdone) begin
        mem_addr <= addr;
        mem_data <= word;
      end
      if (state == WRITE) begin
        addr <= addr + 16'd1;
        rem  <= rem - 16'd1;
      end
      if (state == DONE) start_pc <= orig;
      if (state == ERR) load_error <= 1'b1;
      else if (state == IDLE && accept) load_error <= 1'b0;
    end
endmodule
